// File: rtl/orion_types.sv
// Shared types for the orion memory path.
//   ADDRW / XLEN / MASKW : address, data and byte-mask widths
//   arb_state_t          : mem_arbiter FSM state
//   arb_gnt_e            : which requester holds (or last held) the shared port
//   mem_req_t            : one captured memory request (the holding register)
package orion_types;

    localparam int ADDRW = 32;
    localparam int XLEN  = 32;
    localparam int MASKW = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } arb_gnt_e;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [XLEN-1:0]  wdata;
        logic [MASKW-1:0] mask;
        logic             we;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input combinational round-robin picker.
//   req[1:0] : request vector, bit 0 = imem, bit 1 = dmem
//   last     : requester granted most recently
//   gnt[1:0] : one-hot grant (all zero when nothing requests)
module rr_arb2
    import orion_types::*;
(
    input  logic [1:0] req,
    input  arb_gnt_e   last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a conflict the side that did not win last time goes first.
            2'b11:   gnt = (last == IMEM) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction-fetch (imem) and data (dmem)
// ports of the core. A granted request is captured in a holding register and
// presented on the mem_* port until mem_resp_i; the response is then routed
// back combinationally to the winner.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   imem_*            : fetch request in, fetch data / done pulse out
//   dmem_*            : load/store request in, load data / done pulse out
//   mem_*_o           : shared port request (registered)
//   mem_rdata_i/resp_i: shared port response
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction outstanding; arbitration happens only here
// GNT_I | imem request on the shared port, waiting for mem_resp_i
// GNT_D | dmem request on the shared port, waiting for mem_resp_i
module mem_arbiter
    import orion_types::*;
(
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [ADDRW-1:0] imem_addr_i,
    input  logic             imem_valid_i,
    output logic [XLEN-1:0]  imem_rdata_o,
    output logic             imem_resp_o,

    input  logic [ADDRW-1:0] dmem_addr_i,
    input  logic [XLEN-1:0]  dmem_wdata_i,
    input  logic [MASKW-1:0] dmem_mask_i,
    input  logic             dmem_we_i,
    input  logic             dmem_valid_i,
    output logic [XLEN-1:0]  dmem_rdata_o,
    output logic             dmem_resp_o,

    output logic [ADDRW-1:0] mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    output logic [MASKW-1:0] mem_mask_o,
    output logic             mem_we_o,
    output logic             mem_valid_o,
    input  logic [XLEN-1:0]  mem_rdata_i,
    input  logic             mem_resp_i
);

    arb_state_t state;
    arb_gnt_e   last_gnt;
    mem_req_t   req_q;
    logic [1:0] gnt;

    rr_arb2 u_rr_arb2 (
        .req  ({dmem_valid_i, imem_valid_i}),
        .last (last_gnt),
        .gnt  (gnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= IMEM;
            req_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A stray mem_resp_i here is ignored: only gnt matters.
                    if (gnt[0]) begin
                        req_q.addr  <= imem_addr_i;
                        req_q.wdata <= '0;
                        req_q.mask  <= '1;
                        req_q.we    <= 1'b0;
                        last_gnt    <= IMEM;
                        state       <= GNT_I;
                    end else if (gnt[1]) begin
                        req_q.addr  <= dmem_addr_i;
                        req_q.wdata <= dmem_wdata_i;
                        req_q.mask  <= dmem_mask_i;
                        req_q.we    <= dmem_we_i;
                        last_gnt    <= DMEM;
                        state       <= GNT_D;
                    end
                end
                // Requester valid is not looked at while granted, so a dropped
                // valid still completes and a valid in the resp cycle waits
                // for the following IDLE cycle.
                GNT_I, GNT_D: begin
                    if (mem_resp_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shared port comes straight from flops: no path from requester inputs.
    assign mem_valid_o = (state != IDLE);
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;
    assign mem_mask_o  = req_q.mask;
    assign mem_we_o    = req_q.we;

    assign imem_resp_o  = (state == GNT_I) && mem_resp_i;
    assign dmem_resp_o  = (state == GNT_D) && mem_resp_i;
    assign imem_rdata_o = imem_resp_o ? mem_rdata_i : '0;
    assign dmem_rdata_o = dmem_resp_o ? mem_rdata_i : '0;

endmodule
